// File: rtl/fade_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fade_sequencer
// Brief    : Queued fade-command controller that ramps the PWM brightness
//            one LSB per step toward each target, then holds.
//            Optional cmd_done completion pulse: define FADE_SEQ_DONE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fade_sequencer #(
  parameter int WIDTH           = 4,
  parameter int PEAK_BRIGHTNESS = 15,
  parameter int FIFO_DEPTH      = 4,
  parameter int PERIOD_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [WIDTH-1:0]        cmd_target,
  input  logic [PERIOD_WIDTH-1:0] cmd_period,
  input  logic [PERIOD_WIDTH-1:0] cmd_hold,
  input  logic                    flush,
`ifdef FADE_SEQ_DONE_EN
  output logic                    cmd_done,
`endif
  output logic [WIDTH-1:0]        brightness,
  output logic                    busy
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [WIDTH-1:0]        c_PEAK  = WIDTH'(PEAK_BRIGHTNESS);
  localparam logic [c_CNT_W-1:0]      c_DEPTH = c_CNT_W'(FIFO_DEPTH);
  localparam logic [PERIOD_WIDTH-1:0] c_ONE   = PERIOD_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [WIDTH-1:0]        r_q_target [FIFO_DEPTH];
  logic [PERIOD_WIDTH-1:0] r_q_period [FIFO_DEPTH];
  logic [PERIOD_WIDTH-1:0] r_q_hold   [FIFO_DEPTH];
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [c_CNT_W-1:0]      r_count;

  logic [WIDTH-1:0]        r_brightness;
  logic [WIDTH-1:0]        r_target;
  logic [PERIOD_WIDTH-1:0] r_period;
  logic [PERIOD_WIDTH-1:0] r_hold;
  logic [PERIOD_WIDTH-1:0] r_tick;
  logic [PERIOD_WIDTH-1:0] r_hold_cnt;
  logic                    r_done;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_at_target;
  logic                    w_tick_done;
  logic                    w_hold_done;
  logic [WIDTH-1:0]        w_stepped;
  logic [WIDTH-1:0]        w_tgt_clamped;
  logic [PERIOD_WIDTH-1:0] w_period_fixed;

  assign w_tgt_clamped  = (cmd_target > c_PEAK) ? c_PEAK : cmd_target;
  assign w_period_fixed = (cmd_period == '0) ? c_ONE : cmd_period;
  assign w_push         = cmd_valid && cmd_ready;
  assign w_pop          = (r_state == S_IDLE) && (r_count != '0) && !flush;

  assign w_at_target = (r_brightness == r_target);
  assign w_tick_done = (r_tick == r_period - c_ONE);
  assign w_hold_done = (r_hold == '0) || (r_hold_cnt == r_hold - c_ONE);
  assign w_stepped   = (r_brightness < r_target) ? r_brightness + WIDTH'(1)
                                                 : r_brightness - WIDTH'(1);

  // Command storage carries no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_target[r_wr_ptr] <= w_tgt_clamped;
      r_q_period[r_wr_ptr] <= w_period_fixed;
      r_q_hold[r_wr_ptr]   <= cmd_hold;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    cmd_ready    = (r_count != c_DEPTH) && !flush;
    busy         = (r_state != S_IDLE) || (r_count != '0);
    case (r_state)
      S_IDLE: if (r_count != '0) w_next_state = S_RAMP;
      S_RAMP: begin
        if (w_at_target) w_next_state = S_HOLD;
        else if (w_tick_done && (w_stepped == r_target)) w_next_state = S_HOLD;
      end
      S_HOLD: if (w_hold_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (flush) w_next_state = S_IDLE;
  end

  // Flush freezes brightness but discards the active command's progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_brightness <= '0;
      r_target     <= '0;
      r_period     <= '0;
      r_hold       <= '0;
      r_tick       <= '0;
      r_hold_cnt   <= '0;
      r_done       <= 1'b0;
    end else if (flush) begin
      r_tick     <= '0;
      r_hold_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == S_HOLD) && w_hold_done;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_target   <= r_q_target[r_rd_ptr];
            r_period   <= r_q_period[r_rd_ptr];
            r_hold     <= r_q_hold[r_rd_ptr];
            r_tick     <= '0;
            r_hold_cnt <= '0;
          end
        end
        S_RAMP: begin
          r_hold_cnt <= '0;
          if (!w_at_target) begin
            if (w_tick_done) begin
              r_tick       <= '0;
              r_brightness <= w_stepped;
            end else begin
              r_tick <= r_tick + c_ONE;
            end
          end
        end
        S_HOLD: begin
          if (w_hold_done) r_hold_cnt <= '0;
          else             r_hold_cnt <= r_hold_cnt + c_ONE;
        end
        default: r_tick <= '0;
      endcase
    end
  end

  assign brightness = r_brightness;

`ifdef FADE_SEQ_DONE_EN
  assign cmd_done = r_done;
`else
  logic w_unused_done;
  assign w_unused_done = r_done;
`endif

endmodule
`default_nettype wire

// File: doc/fade_sequencer.md
Name: fade_sequencer

Overview:
Command-driven controller that sequences the brightness value fed to the PWM generator. It replaces the free-running up/down brightness stepper with queued fade commands. Each command carries a target level, a step period and a hold time. Commands enter through a valid/ready handshake, are buffered in a small FIFO and are executed strictly in order. The block ramps the brightness one LSB per step toward each target.

Parameters:
- WIDTH, 4: brightness width in bits.
- PEAK_BRIGHTNESS, 15: maximum legal brightness; targets above it are clamped.
- FIFO_DEPTH, 4: command queue depth; must be a power of 2, minimum 2.
- PERIOD_WIDTH, 8: width of the step-period and hold fields.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  the block can accept a command this cycle.
- cmd_target  in  WIDTH  target brightness.
- cmd_period  in  PERIOD_WIDTH  clocks per one-LSB step; 0 is treated as 1.
- cmd_hold  in  PERIOD_WIDTH  clocks to dwell at the target after arrival.
- flush  in  1  synchronous abort: clear the queue and the active command.
- brightness  out  WIDTH  registered level to the PWM generator.
- busy  out  1  active command present or queue non-empty.

Behaviour:
- Reset (reset low, asynchronous, any time including mid-ramp), all immediate:
  - brightness=0, busy=0, cmd_ready=1.
  - FIFO empty, state IDLE, all counters 0.
- Handshake:
  - A push occurs on a rising edge with cmd_valid && cmd_ready.
  - cmd_ready = !fifo_full && !flush; it is driven only from registered state and flush.
  - When full, a push is refused even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- At enqueue: target is clamped to min(cmd_target, PEAK_BRIGHTNESS); period 0 is stored as 1.
- States:
  - IDLE:
    - FIFO non-empty: pop the head at this edge, load target/period/hold, clear the tick counter, go to RAMP.
    - IDLE always lasts at least one cycle between commands.
  - RAMP:
    - brightness==target: go to HOLD at the next edge with no step.
    - Otherwise tick increments each cycle. At the edge where tick==period-1: tick←0, brightness steps ±1 toward target.
    - First step lands `period` clocks after RAMP entry.
    - If the stepped value equals target, go to HOLD and clear tick.
  - HOLD:
    - Counts `hold` clocks, then goes to IDLE.
    - hold=0: return to IDLE at the next edge.
- Arithmetic:
  - brightness never wraps, never exceeds PEAK_BRIGHTNESS and never goes below 0.
  - Steps are always exactly ±1.
- busy = (state!=IDLE) || (fifo_count!=0).
- flush:
  - Next edge: FIFO emptied, state IDLE, counters cleared.
  - brightness holds its current value.
  - Any push in the same cycle is dropped (cmd_ready is low).
- Latency: command accepted at edge E0 into an empty, idle block → RAMP entry at E1 → first step at E1+period.

Optional Feature:
- Macro: FADE_SEQ_DONE_EN.
- Defined:
  - Adds output port cmd_done (1 bit), registered, reset 0.
  - cmd_done pulses high for exactly one cycle on the edge where HOLD→IDLE (the command completed).
  - No pulse for commands removed by flush or reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, then cmd (target=3, period=2, hold=0) accepted at E0 → brightness 1,2,3 at E3,E5,E7; IDLE at E8; busy=0 after E8.
- From 12, cmd (target=9, period=0, hold=0) → period treated as 1: brightness 11,10,9 on consecutive edges E2,E3,E4.
- PEAK_BRIGHTNESS=12, cmd target=15 period=1 from 0 → brightness stops at 12, never 13; after hold, busy falls.
- Six back-to-back pushes, period=255 → first five accepted (one popped plus four queued); cmd_ready low until the next pop; commands execute in push order.
- Target equal to current level (5→5) with hold=3 → brightness stays 5; RAMP 1 cycle, HOLD 3 cycles; with FADE_SEQ_DONE_EN, one cmd_done pulse.
- Mid-ramp: flush with cmd_valid high → FIFO empty and IDLE next edge, brightness frozen, push dropped. Then reset low mid-ramp → brightness=0 immediately, cmd_ready=1.
